scarv_cop_dispatch: RTL and testbench

- Single-issue instruction sequencer for the ISE coprocessor. Sits between the CPU coprocessor interface and the functional units (FUs).
- Accepts one encoded instruction at a time and latches it. Drives the latched encoding into the combinational instruction decoder and reads back its class, subclass and exception outputs.
- Issues the instruction to exactly one FU selected by decoded class, then waits for that FU to complete.
- Returns a status and optional GPR writeback to the CPU, with a timeout watchdog on the FU.

---
 rtl/scarv_cop_dispatch.sv | 161 ++++++++++++++++
 tb/tb_scarv_cop_dispatch.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scarv_cop_dispatch.sv
// Single-issue sequencer for the ISE coprocessor: accepts one instruction,
// decodes it, issues it to one functional unit and returns a status to the CPU.
module scarv_cop_dispatch #(
    parameter int unsigned TIMEOUT_CYCLES = 64,  // must be >= 2
    parameter int unsigned CNT_W          = 7    // 2**CNT_W > TIMEOUT_CYCLES
) (
    input  logic        g_clk,
    input  logic        g_reset,
    input  logic        cpu_insn_req,
    output logic        cpu_insn_ack,
    input  logic [31:0] cpu_insn_enc,
    input  logic [31:0] cpu_rs1_val,
    output logic        cpu_rsp_valid,
    input  logic        cpu_rsp_ready,
    output logic [1:0]  cpu_rsp_status,
    output logic        cpu_rsp_wen,
    output logic [4:0]  cpu_rsp_rd,
    output logic [31:0] cpu_rsp_data,
    output logic [31:0] dec_encoded,
    input  logic        dec_exception,
    input  logic [3:0]  dec_class,
    input  logic [4:0]  dec_subclass,
    input  logic [4:0]  dec_rd,
    output logic [15:0] fu_ivalid,
    output logic [4:0]  fu_subclass,
    output logic [31:0] fu_rs1,
    input  logic [15:0] fu_done,
    input  logic [15:0] fu_wen,
    input  logic [31:0] fu_wdata,
    output logic        fu_abort
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_ILLEGAL = 2'd1;
    localparam logic [1:0] ST_TIMEOUT = 2'd2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t             state_q, state_d;
    logic [31:0]        enc_q, enc_d;
    logic [31:0]        rs1_q, rs1_d;
    logic [3:0]         class_q, class_d;
    logic [4:0]         subclass_q, subclass_d;
    logic [4:0]         rd_q, rd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         status_q, status_d;
    logic               wen_q, wen_d;
    logic [31:0]        data_q, data_d;
    logic               done_hit;

    // Only the completion strobe of the FU that was issued to counts.
    assign done_hit = fu_done[class_q];

    always_comb begin
        state_d      = state_q;
        enc_d        = enc_q;
        rs1_d        = rs1_q;
        class_d      = class_q;
        subclass_d   = subclass_q;
        rd_d         = rd_q;
        cnt_d        = cnt_q;
        status_d     = status_q;
        wen_d        = wen_q;
        data_d       = data_q;
        cpu_insn_ack = 1'b0;
        fu_abort     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cpu_insn_req && !g_reset) begin
                    cpu_insn_ack = 1'b1;
                    enc_d        = cpu_insn_enc;
                    rs1_d        = cpu_rs1_val;
                    state_d      = S_DECODE;
                end
            end
            S_DECODE: begin
                class_d    = dec_class;
                subclass_d = dec_subclass;
                rd_d       = dec_rd;
                if (dec_exception || (dec_class == 4'd0)) begin
                    status_d = ST_ILLEGAL;
                    wen_d    = 1'b0;
                    data_d   = 32'd0;
                    state_d  = S_RESP;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // A completion in the last watchdog cycle still wins over the abort.
                if (done_hit) begin
                    status_d = ST_OK;
                    wen_d    = fu_wen[class_q];
                    data_d   = fu_wdata;
                    state_d  = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    fu_abort = !g_reset;
                    status_d = ST_TIMEOUT;
                    wen_d    = 1'b0;
                    data_d   = 32'd0;
                    state_d  = S_RESP;
                end
            end
            S_RESP: begin
                if (cpu_rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state_q    <= S_IDLE;
            enc_q      <= '0;
            rs1_q      <= '0;
            class_q    <= '0;
            subclass_q <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            status_q   <= '0;
            wen_q      <= 1'b0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            enc_q      <= enc_d;
            rs1_q      <= rs1_d;
            class_q    <= class_d;
            subclass_q <= subclass_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            status_q   <= status_d;
            wen_q      <= wen_d;
            data_q     <= data_d;
        end
    end

    assign dec_encoded    = enc_q;
    assign fu_subclass    = subclass_q;
    assign fu_rs1         = rs1_q;
    assign fu_ivalid      = (state_q == S_ISSUE) ? (16'd1 << class_q) : 16'd0;
    assign cpu_rsp_valid  = (state_q == S_RESP);
    assign cpu_rsp_status = cpu_rsp_valid ? status_q : 2'd0;
    assign cpu_rsp_wen    = cpu_rsp_valid & wen_q;
    assign cpu_rsp_rd     = cpu_rsp_valid ? rd_q : 5'd0;
    assign cpu_rsp_data   = cpu_rsp_valid ? data_q : 32'd0;

endmodule

// File: tb/tb_scarv_cop_dispatch.sv
// Directed self-checking bench for scarv_cop_dispatch; the decoder and FUs are
// modelled by directly driven stimulus signals.
module tb_scarv_cop_dispatch;

    logic        clk = 1'b0;
    logic        g_reset;
    logic        cpu_insn_req;
    logic        cpu_insn_ack;
    logic [31:0] cpu_insn_enc;
    logic [31:0] cpu_rs1_val;
    logic        cpu_rsp_valid;
    logic        cpu_rsp_ready;
    logic [1:0]  cpu_rsp_status;
    logic        cpu_rsp_wen;
    logic [4:0]  cpu_rsp_rd;
    logic [31:0] cpu_rsp_data;
    logic [31:0] dec_encoded;
    logic        dec_exception;
    logic [3:0]  dec_class;
    logic [4:0]  dec_subclass;
    logic [4:0]  dec_rd;
    logic [15:0] fu_ivalid;
    logic [4:0]  fu_subclass;
    logic [31:0] fu_rs1;
    logic [15:0] fu_done;
    logic [15:0] fu_wen;
    logic [31:0] fu_wdata;
    logic        fu_abort;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    scarv_cop_dispatch #(.TIMEOUT_CYCLES(64), .CNT_W(7)) dut (
        .g_clk(clk), .g_reset(g_reset),
        .cpu_insn_req(cpu_insn_req), .cpu_insn_ack(cpu_insn_ack),
        .cpu_insn_enc(cpu_insn_enc), .cpu_rs1_val(cpu_rs1_val),
        .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_ready(cpu_rsp_ready),
        .cpu_rsp_status(cpu_rsp_status), .cpu_rsp_wen(cpu_rsp_wen),
        .cpu_rsp_rd(cpu_rsp_rd), .cpu_rsp_data(cpu_rsp_data),
        .dec_encoded(dec_encoded), .dec_exception(dec_exception),
        .dec_class(dec_class), .dec_subclass(dec_subclass), .dec_rd(dec_rd),
        .fu_ivalid(fu_ivalid), .fu_subclass(fu_subclass), .fu_rs1(fu_rs1),
        .fu_done(fu_done), .fu_wen(fu_wen), .fu_wdata(fu_wdata),
        .fu_abort(fu_abort)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        g_reset = 1'b1;
        tick();
        tick();
        #1;
        n_cmp++;
        if ({cpu_insn_ack, cpu_rsp_valid, cpu_rsp_status, cpu_rsp_wen, cpu_rsp_rd, cpu_rsp_data,
             dec_encoded, fu_ivalid, fu_subclass, fu_rs1, fu_abort} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got valid=%b ack=%b enc=%h ivalid=%h abort=%b, required all zero",
                     cpu_rsp_valid, cpu_insn_ack, dec_encoded, fu_ivalid, fu_abort);
        end
        g_reset = 1'b0;
        tick();
        #1;
        $display("reset: outputs checked");
    endtask

    task automatic test_legal;
        dec_exception = 1'b0; dec_class = 4'd4; dec_subclass = 5'd3; dec_rd = 5'd7;
        fu_wen = 16'h0010; fu_wdata = 32'hDEADBEEF; fu_done = 16'h0;
        cpu_insn_enc = 32'h12345678; cpu_rs1_val = 32'h0000A5A5; cpu_insn_req = 1'b1;
        #1;
        n_cmp++;
        if (cpu_insn_ack !== 1'b1) begin n_err++; $display("FAIL legal_ack: got %b required 1", cpu_insn_ack); end
        tick(); cpu_insn_req = 1'b0; #1;
        n_cmp++;
        if (dec_encoded !== 32'h12345678 || cpu_insn_ack !== 1'b0 || fu_ivalid !== 16'h0) begin
            n_err++;
            $display("FAIL legal_decode: got enc=%h ack=%b ivalid=%h required enc=12345678 ack=0 ivalid=0000",
                     dec_encoded, cpu_insn_ack, fu_ivalid);
        end
        tick(); #1;
        n_cmp++;
        if (fu_ivalid !== 16'h0010 || fu_rs1 !== 32'h0000A5A5 || fu_subclass !== 5'd3) begin
            n_err++;
            $display("FAIL legal_issue: got ivalid=%h rs1=%h sub=%0d required 0010 0000a5a5 3",
                     fu_ivalid, fu_rs1, fu_subclass);
        end
        tick(); fu_done = 16'h0010; #1;
        n_cmp++;
        if (fu_ivalid !== 16'h0 || cpu_rsp_valid !== 1'b0 || fu_subclass !== 5'd3) begin
            n_err++;
            $display("FAIL legal_wait: got ivalid=%h valid=%b sub=%0d required 0000 0 3",
                     fu_ivalid, cpu_rsp_valid, fu_subclass);
        end
        tick(); fu_done = 16'h0; fu_wdata = 32'h0; #1;
        n_cmp++;
        if (cpu_rsp_valid !== 1'b1 || cpu_rsp_status !== 2'd0 || cpu_rsp_wen !== 1'b1 ||
            cpu_rsp_rd !== 5'd7 || cpu_rsp_data !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL legal_resp: got v=%b st=%0d wen=%b rd=%0d data=%h required 1 0 1 7 deadbeef",
                     cpu_rsp_valid, cpu_rsp_status, cpu_rsp_wen, cpu_rsp_rd, cpu_rsp_data);
        end
        cpu_rsp_ready = 1'b1;
        tick(); cpu_rsp_ready = 1'b0; #1;
        n_cmp++;
        if (cpu_rsp_valid !== 1'b0 || cpu_rsp_wen !== 1'b0 || cpu_rsp_data !== 32'h0) begin
            n_err++;
            $display("FAIL legal_idle: got v=%b wen=%b data=%h required 0 0 0",
                     cpu_rsp_valid, cpu_rsp_wen, cpu_rsp_data);
        end
        $display("legal: class 4 instruction completed");
    endtask

    task automatic test_illegal(input logic exc, input logic [3:0] cls);
        dec_exception = exc; dec_class = cls; dec_rd = 5'd12;
        cpu_insn_enc = 32'hFFFF0000; cpu_insn_req = 1'b1;
        #1;
        n_cmp++;
        if (cpu_insn_ack !== 1'b1) begin n_err++; $display("FAIL illegal_ack: got %b required 1", cpu_insn_ack); end
        tick(); cpu_insn_req = 1'b0; #1;
        n_cmp++;
        if (cpu_rsp_valid !== 1'b0 || fu_ivalid !== 16'h0) begin
            n_err++;
            $display("FAIL illegal_c1: got v=%b ivalid=%h required 0 0000", cpu_rsp_valid, fu_ivalid);
        end
        tick(); #1;
        n_cmp++;
        if (cpu_rsp_valid !== 1'b1 || cpu_rsp_status !== 2'd1 || cpu_rsp_wen !== 1'b0 || fu_ivalid !== 16'h0) begin
            n_err++;
            $display("FAIL illegal_resp: got v=%b st=%0d wen=%b ivalid=%h required 1 1 0 0000",
                     cpu_rsp_valid, cpu_rsp_status, cpu_rsp_wen, fu_ivalid);
        end
        cpu_rsp_ready = 1'b1;
        tick(); cpu_rsp_ready = 1'b0; dec_exception = 1'b0; #1;
        $display("illegal: exc=%b class=%0d responded", exc, cls);
    endtask

    task automatic test_timeout;
        int abort_cnt = 0;
        int abort_at = 0;
        dec_exception = 1'b0; dec_class = 4'd2; dec_rd = 5'd3;
        fu_wen = 16'hFFFF; fu_wdata = 32'h77777777; cpu_insn_req = 1'b1;
        tick(); cpu_insn_req = 1'b0;
        tick();
        for (int i = 1; i <= 64; i++) begin
            tick();
            fu_done = (i == 10) ? 16'hFFFB : 16'h0;
            #1;
            if (fu_abort === 1'b1) begin abort_cnt++; abort_at = i; end
        end
        tick(); fu_done = 16'h0; #1;
        n_cmp++;
        if (abort_cnt != 1 || abort_at != 64) begin
            n_err++;
            $display("FAIL timeout_abort: got %0d pulses last at wait cycle %0d required 1 at 64", abort_cnt, abort_at);
        end
        n_cmp++;
        if (cpu_rsp_valid !== 1'b1 || cpu_rsp_status !== 2'd2 || cpu_rsp_wen !== 1'b0 || fu_abort !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_resp: got v=%b st=%0d wen=%b abort=%b required 1 2 0 0",
                     cpu_rsp_valid, cpu_rsp_status, cpu_rsp_wen, fu_abort);
        end
        cpu_rsp_ready = 1'b1;
        tick(); cpu_rsp_ready = 1'b0; cpu_insn_req = 1'b1; dec_exception = 1'b1; #1;
        n_cmp++;
        if (cpu_rsp_valid !== 1'b0 || cpu_insn_ack !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_idle: got v=%b ack=%b required 0 1", cpu_rsp_valid, cpu_insn_ack);
        end
        tick(); cpu_insn_req = 1'b0;
        tick();
        cpu_rsp_ready = 1'b1;
        tick(); cpu_rsp_ready = 1'b0; dec_exception = 1'b0; #1;
        $display("timeout: watchdog abort observed at wait cycle %0d", abort_at);
    endtask

    task automatic test_done_at_timeout;
        int abort_seen = 0;
        dec_exception = 1'b0; dec_class = 4'd5; dec_rd = 5'd20;
        fu_wen = 16'hFFDF; fu_wdata = 32'h00001111; cpu_insn_req = 1'b1;
        tick(); cpu_insn_req = 1'b0;
        tick();
        for (int i = 1; i <= 64; i++) begin
            tick();
            fu_done = (i == 64) ? 16'h0020 : 16'h0;
            #1;
            if (fu_abort === 1'b1) abort_seen++;
        end
        tick(); fu_done = 16'h0; #1;
        n_cmp++;
        if (abort_seen != 0) begin
            n_err++;
            $display("FAIL race_abort: got %0d abort pulses required 0", abort_seen);
        end
        n_cmp++;
        if (cpu_rsp_valid !== 1'b1 || cpu_rsp_status !== 2'd0 || cpu_rsp_wen !== 1'b0 ||
            cpu_rsp_rd !== 5'd20 || cpu_rsp_data !== 32'h00001111) begin
            n_err++;
            $display("FAIL race_resp: got v=%b st=%0d wen=%b rd=%0d data=%h required 1 0 0 20 00001111",
                     cpu_rsp_valid, cpu_rsp_status, cpu_rsp_wen, cpu_rsp_rd, cpu_rsp_data);
        end
        cpu_rsp_ready = 1'b1;
        tick(); cpu_rsp_ready = 1'b0; #1;
        $display("done_at_timeout: completion won over watchdog");
    endtask

    task automatic test_back_to_back;
        dec_exception = 1'b0; dec_class = 4'd1; dec_rd = 5'd9;
        fu_wen = 16'h0002; fu_wdata = 32'hCAFEF00D; cpu_insn_req = 1'b1;
        cpu_insn_enc = 32'h0000ABCD;
        tick(); cpu_insn_req = 1'b0;
        tick();
        tick(); fu_done = 16'h0002;
        tick(); fu_done = 16'h0; fu_wdata = 32'h0;
        cpu_insn_req = 1'b1; cpu_insn_enc = 32'h0BADC0DE;
        for (int i = 0; i < 10; i++) begin
            #1;
            n_cmp++;
            if (cpu_rsp_valid !== 1'b1 || cpu_rsp_status !== 2'd0 || cpu_rsp_wen !== 1'b1 ||
                cpu_rsp_rd !== 5'd9 || cpu_rsp_data !== 32'hCAFEF00D || cpu_insn_ack !== 1'b0) begin
                n_err++;
                $display("FAIL hold_c%0d: got v=%b st=%0d wen=%b rd=%0d data=%h ack=%b required 1 0 1 9 cafef00d 0",
                         i, cpu_rsp_valid, cpu_rsp_status, cpu_rsp_wen, cpu_rsp_rd, cpu_rsp_data, cpu_insn_ack);
            end
            tick();
        end
        cpu_rsp_ready = 1'b1;
        #1;
        n_cmp++;
        if (cpu_insn_ack !== 1'b0) begin
            n_err++;
            $display("FAIL handshake_ack: got %b required 0", cpu_insn_ack);
        end
        tick(); cpu_rsp_ready = 1'b0; dec_exception = 1'b1; #1;
        n_cmp++;
        if (cpu_rsp_valid !== 1'b0 || cpu_insn_ack !== 1'b1) begin
            n_err++;
            $display("FAIL next_ack: got v=%b ack=%b required 0 1", cpu_rsp_valid, cpu_insn_ack);
        end
        tick(); cpu_insn_req = 1'b0; #1;
        n_cmp++;
        if (dec_encoded !== 32'h0BADC0DE) begin
            n_err++;
            $display("FAIL next_enc: got %h required 0badc0de", dec_encoded);
        end
        tick(); #1;
        n_cmp++;
        if (cpu_rsp_valid !== 1'b1 || cpu_rsp_status !== 2'd1) begin
            n_err++;
            $display("FAIL next_resp: got v=%b st=%0d required 1 1", cpu_rsp_valid, cpu_rsp_status);
        end
        cpu_rsp_ready = 1'b1;
        tick(); cpu_rsp_ready = 1'b0; dec_exception = 1'b0; #1;
        $display("back_to_back: backpressure and next acceptance checked");
    endtask

    task automatic test_reset_mid;
        int late_valid = 0;
        dec_exception = 1'b0; dec_class = 4'd3; dec_rd = 5'd4;
        fu_wen = 16'h0008; fu_wdata = 32'h13579BDF; cpu_insn_req = 1'b1;
        cpu_insn_enc = 32'h33334444; cpu_rs1_val = 32'h55556666;
        tick(); cpu_insn_req = 1'b0;
        tick();
        tick();
        tick(); g_reset = 1'b1; fu_done = 16'h0008; #1;
        n_cmp++;
        if (fu_abort !== 1'b0) begin n_err++; $display("FAIL rst_abort: got %b required 0", fu_abort); end
        tick(); g_reset = 1'b0; fu_done = 16'h0; #1;
        n_cmp++;
        if ({cpu_insn_ack, cpu_rsp_valid, cpu_rsp_status, cpu_rsp_wen, cpu_rsp_rd, cpu_rsp_data,
             dec_encoded, fu_ivalid, fu_subclass, fu_rs1, fu_abort} !== '0) begin
            n_err++;
            $display("FAIL rst_outputs: got v=%b enc=%h rs1=%h data=%h required all zero",
                     cpu_rsp_valid, dec_encoded, fu_rs1, cpu_rsp_data);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            if (cpu_rsp_valid !== 1'b0) late_valid++;
        end
        n_cmp++;
        if (late_valid != 0) begin
            n_err++;
            $display("FAIL rst_no_resp: got %0d valid cycles required 0", late_valid);
        end
        cpu_insn_req = 1'b1; fu_wdata = 32'h00005A5A;
        #1;
        n_cmp++;
        if (cpu_insn_ack !== 1'b1) begin n_err++; $display("FAIL rst_reaccept: got %b required 1", cpu_insn_ack); end
        tick(); cpu_insn_req = 1'b0;
        tick();
        tick(); fu_done = 16'h0008;
        tick(); fu_done = 16'h0; #1;
        n_cmp++;
        if (cpu_rsp_valid !== 1'b1 || cpu_rsp_status !== 2'd0 || cpu_rsp_wen !== 1'b1 ||
            cpu_rsp_rd !== 5'd4 || cpu_rsp_data !== 32'h00005A5A) begin
            n_err++;
            $display("FAIL rst_after_resp: got v=%b st=%0d wen=%b rd=%0d data=%h required 1 0 1 4 00005a5a",
                     cpu_rsp_valid, cpu_rsp_status, cpu_rsp_wen, cpu_rsp_rd, cpu_rsp_data);
        end
        cpu_rsp_ready = 1'b1;
        tick(); cpu_rsp_ready = 1'b0; #1;
        $display("reset_mid: wait-state reset discarded response");
    endtask

    initial begin
        g_reset = 1'b1; cpu_insn_req = 1'b0; cpu_insn_enc = 32'h0; cpu_rs1_val = 32'h0;
        cpu_rsp_ready = 1'b0; dec_exception = 1'b0; dec_class = 4'd0; dec_subclass = 5'd0;
        dec_rd = 5'd0; fu_done = 16'h0; fu_wen = 16'h0; fu_wdata = 32'h0;
        test_reset();
        test_legal();
        test_illegal(1'b1, 4'd4);
        test_illegal(1'b0, 4'd0);
        test_timeout();
        test_done_at_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
